// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry (main + skid) pipeline stage with stall, flush and drop counter; optional counter via PIPE_STAGE_DROP_CNT_EN
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             stall,
    input  logic             flush,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             flush_seen
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             drain;

    // Skid must be free to take a beat; stall and flush both refuse new input.
    assign in_ready  = !skid_valid && !stall && !flush;
    // Reset gating keeps out_valid low before the first reset edge has cleared main_valid.
    assign out_valid = main_valid && !stall && !reset;
    assign out_data  = main_data;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Main/skid storage: flush clears valids only, stall freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!stall) begin
            if (drain) begin
                if (skid_valid) begin
                    // Skid beat is older than any incoming beat, so it moves up first.
                    main_data  <= skid_data;
                    main_valid <= 1'b1;
                    skid_valid <= accept;
                    if (accept) begin
                        skid_data <= in_data;
                    end
                end else begin
                    main_valid <= accept;
                    if (accept) begin
                        main_data <= in_data;
                    end
                end
            end else if (accept) begin
                if (!main_valid) begin
                    main_data  <= in_data;
                    main_valid <= 1'b1;
                end else begin
                    skid_data  <= in_data;
                    skid_valid <= 1'b1;
                end
            end
        end
    end

    // Sticky record that a flush has ever happened since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_seen <= 1'b0;
        end else if (flush) begin
            flush_seen <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_DROP_CNT_EN
    logic [1:0]       n_held;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_reg;

    assign n_held  = {1'b0, main_valid} + {1'b0, skid_valid};
    assign cnt_sum = {1'b0, cnt_reg} + (CNT_W+1)'(n_held);

    // Count beats discarded by flush, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (flush) begin
            if (cnt_sum[CNT_W]) begin
                cnt_reg <= {CNT_W{1'b1}};
            end else begin
                cnt_reg <= cnt_sum[CNT_W-1:0];
            end
        end
    end

    assign drop_cnt = cnt_reg;
`else
    assign drop_cnt = '0;
`endif

endmodule
